// File: rtl/mac_tile_mp.sv
// Multi-precision SIMD MAC tile: per-lane unsigned activation slice times a
// signed weight shared across a runtime-selected group of lanes.
module mac_tile_mp #(
    parameter int bw      = 8,
    parameter int lanes   = 4,
    parameter int psum_bw = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [bw-1:0]              in_w,
    output logic [bw-1:0]              out_e,
    input  logic [1:0]                 inst_w,
    output logic [1:0]                 inst_e,
    input  logic [lanes*psum_bw-1:0]   in_n,
    output logic [lanes*psum_bw-1:0]   out_s,
    input  logic [1:0]                 cfg_mode,
    output logic                       wt_ready
);

    localparam int sw         = bw / lanes;
    localparam int lg         = $clog2(lanes);
    localparam int cw         = lg;
    localparam int prod_w     = sw + bw + 1;
    localparam int mode_max_i = (lg > 3) ? 3 : lg;
    localparam logic [1:0] mode_max = 2'(mode_max_i);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        READY = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t                     state_reg, state_next;
    logic [1:0]                 mode_reg, mode_next;
    logic [cw-1:0]              cnt_reg, cnt_next;
    logic [bw-1:0]              a_reg, a_next;
    logic [lanes*psum_bw-1:0]   c_reg, c_next;
    logic [1:0]                 inst_reg, inst_next;
    logic                       exe_reg, exe_next;
    logic [bw-1:0]              w_reg [lanes];
    logic                       w_we;

    logic [1:0]                 cfg_clamp;
    logic                       sample_mode;
    logic [1:0]                 mode_eff;
    logic [cw-1:0]              last_idx;

    assign cfg_clamp   = (cfg_mode > mode_max) ? mode_max : cfg_mode;
    assign sample_mode = (state_reg == LOAD) && (cnt_reg == '0);
    // The first beat is counted against the mode being sampled in the same cycle.
    assign mode_eff    = sample_mode ? cfg_clamp : mode_reg;
    assign last_idx    = cw'((1 << mode_eff) - 1);

    always_comb begin
        state_next = state_reg;
        mode_next  = mode_eff;
        cnt_next   = cnt_reg;
        a_next     = a_reg;
        c_next     = c_reg;
        inst_next  = {inst_w[1], 1'b0};
        exe_next   = inst_w[1];
        w_we       = 1'b0;
        case (state_reg)
            LOAD: begin
                if (inst_w[0]) begin
                    w_we = 1'b1;
                    if (cnt_reg == last_idx) begin
                        cnt_next   = '0;
                        state_next = READY;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            READY, EXEC: begin
                if (inst_w[0]) begin
                    a_next       = in_w;
                    inst_next[0] = 1'b1;
                end
                if (inst_w[1]) begin
                    a_next = in_w;
                    c_next = in_n;
                end
                if (state_reg == READY && inst_w[1]) begin
                    state_next = EXEC;
                end
                if (state_reg == EXEC && exe_reg && !inst_w[1]) begin
                    state_next = LOAD;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = LOAD;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= LOAD;
            mode_reg  <= '0;
            cnt_reg   <= '0;
            a_reg     <= '0;
            c_reg     <= '0;
            inst_reg  <= '0;
            exe_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            mode_reg  <= mode_next;
            cnt_reg   <= cnt_next;
            a_reg     <= a_next;
            c_reg     <= c_next;
            inst_reg  <= inst_next;
            exe_reg   <= exe_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < lanes; i++) begin
                w_reg[i] <= '0;
            end
        end else if (w_we) begin
            w_reg[cnt_reg] <= in_w;
        end
    end

    assign out_e    = a_reg;
    assign inst_e   = inst_reg;
    assign wt_ready = (state_reg != LOAD);

    generate
        for (genvar gi = 0; gi < lanes; gi++) begin : g_lane
            logic [cw-1:0]            grp;
            logic [sw-1:0]            slice;
            logic signed [prod_w-1:0] a_ext;
            logic signed [prod_w-1:0] w_ext;
            logic signed [prod_w-1:0] prod;

            // lanes/G consecutive lanes share one weight: g = j >> (lg - mode).
            assign grp   = cw'(gi >> (lg - int'(mode_reg)));
            assign slice = a_reg[gi*sw +: sw];
            assign a_ext = {{(bw+1){1'b0}}, slice};
            assign w_ext = {{(sw+1){w_reg[grp][bw-1]}}, w_reg[grp]};
            assign prod  = a_ext * w_ext;
            assign out_s[gi*psum_bw +: psum_bw] = c_reg[gi*psum_bw +: psum_bw]
                + {{(psum_bw-prod_w){prod[prod_w-1]}}, prod};
        end
    endgenerate

endmodule

// File: doc/mac_tile_mp.md
# mac_tile_mp

Multi-precision SIMD MAC tile: a parametrised successor to the two-lane 2b/4b tile, with a generic lane count and a runtime mode that selects how many distinct weights share the lanes. It is the processing element of the systolic array. Activations and instructions flow west to east, partial sums flow north to south, and weights are absorbed from the west bus during a load phase. Each lane multiplies an unsigned activation slice by a signed weight. Lane results stay per-lane; any slice recombination (shift/add) happens downstream.

## Interface
- bw, 8: width of the activation/weight bus and of each signed weight.
- lanes, 4: number of MAC lanes. Power of 2, at least 2, divides bw. Slice width sw = bw/lanes.
- psum_bw, 16: width of each per-lane partial sum.
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- in_w  input  bw  activation, or weight during LOAD, from the west.
- out_e  output  bw  registered activation forwarded east.
- inst_w  input  2  [1]=execute, [0]=kernel load, from the west.
- inst_e  output  2  registered instruction forwarded east.
- in_n  input  lanes*psum_bw  per-lane psum from the north; lane j at bits [j*psum_bw +: psum_bw].
- out_s  output  lanes*psum_bw  per-lane psum to the south.
- cfg_mode  input  2  G = 2^cfg_mode weight groups. Values above log2(lanes) clamp to log2(lanes).
- wt_ready  output  1  high when the state is not LOAD.

## Operation
- States: LOAD (the reset state), READY, EXEC.
- Registers: mode_q; load_cnt (0..lanes-1); w_q[0..lanes-1] (bw bits, signed); a_q (bw); c_q[lanes]; inst_q; exe_prev.
- mode_q is sampled every cycle while state=LOAD and load_cnt=0. It is frozen otherwise, so cfg_mode changes outside that window take effect only at the next LOAD.
- LOAD, with inst_w[0]=1:
  - w_q[load_cnt] <= in_w; load_cnt increments.
  - When load_cnt = G-1, load_cnt clears and the state goes to READY.
  - a_q is not updated and inst_e[0] is 0, so weights are absorbed and not forwarded.
- LOAD, with inst_w[1]=1: ignored for a_q and c_q. inst_e[1] is still forwarded.
- READY and EXEC:
  - inst_w[0]=1: a_q <= in_w and inst_e[0] <= 1. This passes weights through to later tiles; w_q is unchanged.
  - inst_w[1]=1: a_q <= in_w and c_q[j] <= in_n lane j.
- Transitions:
  - READY -> EXEC when inst_w[1]=1.
  - EXEC -> LOAD on the falling edge of execute (exe_prev=1, inst_w[1]=0). load_cnt resets to 0.
- inst_e[1] <= inst_w[1] every cycle, in all states.
- Lane j arithmetic:
  - slice s_j = a_q[j*sw +: sw], unsigned.
  - group g = j / (lanes/G).
  - out_s[j] = c_q[j] + sext(s_j * w_q[g]), truncated to psum_bw. Wrap-around on overflow, no saturation.
- Lane grouping per mode, for bw=8 and lanes=4:
  - mode0: all lanes use w_q[0] (one 8b activation split into four 2b slices).
  - mode1: lanes 0-1 use w_q[0], lanes 2-3 use w_q[1].
  - mode2: each lane j uses w_q[j].
- Reset mid-operation: on the next edge, every register returns to its reset value and the state is LOAD with load_cnt=0. Weights loaded before reset are discarded.

## Timing
- Reset values:
  - out_e = 0, inst_e = 0, wt_ready = 0.
  - w_q, a_q, c_q all 0, so out_s = 0 on every lane.
  - mode_q = 0, load_cnt = 0, exe_prev = 0.
- out_e and inst_e: 1-cycle latency from in_w / inst_w.
- out_s: combinational from registers, valid the cycle after inst_w[1] is sampled.
- Load phase: takes exactly G beats of inst_w[0]. Beats need not be consecutive; gaps hold load_cnt.
- wt_ready rises the cycle after the G-th beat is sampled.
- Re-arm: the state is LOAD one cycle after the execute falling edge. The next weight beat is accepted in that cycle.
- inst_w[0] and inst_w[1] both high in LOAD: the load beat takes effect and execute is ignored.
- Both high in READY/EXEC: a_q and c_q update, inst_e = 2'b11.

## Test plan
- Mode2 load and execute (bw=8, lanes=4):
  - Load weights 0x01, 0xFE, 0x03, 0xFC (four beats).
  - Execute with in_w=0xE4 and every in_n lane = 10.
  - Expect out_s lanes 0..3 = 10, 8, 16, 0xFFFE; inst_e[0] stays 0 throughout the load.
- Mode0, single beat:
  - Load 0x05; wt_ready rises after 1 beat.
  - Execute with in_w=0xE4, c=0 -> lanes = 0, 5, 10, 15.
- Pass-through:
  - In READY, drive inst_w=01 with in_w=0x7A.
  - Next cycle: out_e=0x7A, inst_e=01, weights unchanged (a repeat execute gives the same out_s).
- Re-arm and mode freeze:
  - Change cfg_mode 0 -> 2 during EXEC; out_s grouping stays mode0.
  - On the execute falling edge, the state goes to LOAD; four beats are then required.
- Overflow wrap:
  - Mode2 with w_q[3]=0x7F, slice3=3, c=0x7FFF -> lane3 = 0x817C.
- Reset mid-load:
  - Assert reset after 2 of 4 mode2 beats.
  - Expect all outputs 0 and wt_ready=0; a fresh 4-beat load is required.
